cpu_lsu: RTL and testbench
==========================

Name: cpu_lsu

Overview:
Parametrised load/store unit for the next-generation core. It replaces the single-cycle combinational data-RAM path with a handshaked, multi-cycle memory port. It supports byte, halfword and word accesses with sign/zero extension, byte enables, alignment checking and a wait-state timeout. It sits between the core's execute stage and the data memory, and drives a stall (busy) back to the core.

Parameters:
MEM_AW, 12, word-address width presented to data memory (mem_addr = req_addr[MEM_AW+1:2])
TIMEOUT, 255, maximum cycles spent in REQ+WAIT before aborting with error; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core access request
req_ready  out  1  LSU accepts request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned/illegal size or timeout, qualified by rsp_valid
busy  out  1  stall to core; high whenever state != IDLE
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  memory write
mem_addr  out  MEM_AW  word address
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset values: state=IDLE; all outputs 0 except req_ready=1; timeout counter=0; latched request registers=0. Reset asserted mid-operation aborts the access immediately; no response is issued afterwards.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. Request accepted when req_valid=1.
  - Misaligned or illegal access (size 3; half with addr[0]=1; word with addr[1:0]!=0) -> RESP with err=1. No memory access is made.
  - Otherwise latch we/size/unsigned/addr/wdata -> REQ.
- REQ: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata come from the latched values and are stable until grant.
  - mem_gnt with store -> RESP, err=0.
  - mem_gnt with load and mem_rvalid=1 in the same cycle -> capture data -> RESP.
  - mem_gnt with load otherwise -> WAIT.
- WAIT: mem_req=0. mem_rvalid -> capture and extend data -> RESP.
- Timeout: the counter clears on acceptance and increments each cycle in REQ or WAIT. If TIMEOUT!=0 and the counter reaches TIMEOUT before completion -> RESP with err=1, rdata=0, mem_req dropped. A mem_rvalid arriving later, or any mem_rvalid in IDLE/RESP, is ignored.
- RESP: rsp_valid=1 for exactly one cycle, rsp_rdata/rsp_err registered -> IDLE. Minimum latency request-to-rsp_valid: 2 cycles (grant in the first REQ cycle); error path: 1 cycle.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extract: lane = mem_rdata >> (8*addr[1:0]). Byte uses lane[7:0] and half uses lane[15:0], each sign- or zero-extended to 32 bits per the latched unsigned flag. Word uses mem_rdata unchanged; the extension flag has no effect.
- req_valid while busy is ignored (req_ready=0); the core must hold the request.

Test Plan:
- Store word addr 0x0000_0010, wdata 0xDEADBEEF, mem_gnt immediate -> mem_addr=4, mem_be=4'b1111, mem_wdata=0xDEADBEEF; rsp_valid pulse 2 cycles after request, err=0, rdata=0.
- Store byte addr 0x13, wdata 0x000000A5 -> mem_be=4'b1000, mem_wdata=0xA5A5A5A5.
- Load byte addr 0x2 signed, memory returns 0x12F43456 after 3 wait cycles -> rsp_rdata=0xFFFFFFF4. Repeat unsigned -> 0x000000F4. Load half addr 0x2 unsigned -> 0x000012F4.
- Load word addr 0x6 -> rsp_valid one cycle after accept, rsp_err=1, mem_req never asserted. Repeat with req_size=3 -> same result.
- TIMEOUT=4, mem_gnt held low -> mem_req high for 4 cycles then low; rsp_valid with err=1. A late mem_rvalid is ignored and the next request completes normally.
- Assert rst_n low while in WAIT -> all outputs reset, busy=0, req_ready=1. No rsp_valid follows, even when mem_rvalid arrives after reset release.

Source files
------------

// File: rtl/cpu_lsu.sv
// Handshaked load/store unit: byte/half/word accesses with extension, byte
// enables, alignment checking and a REQ+WAIT timeout toward data memory.
module cpu_lsu #(
   parameter int MEM_AW  = 12,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state_o
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

   state_e         state_q;
   logic           we_q, uns_q;
   logic [1:0]     size_q;
   logic [31:0]    addr_q, wdata_q;
   logic [CW-1:0]  cnt_q;
   logic           req_ready_q, busy_q, rsp_valid_q, rsp_err_q, mem_req_q;
   logic [31:0]    rsp_rdata_q;

   logic           misaligned;
   logic           timeout_hit;
   logic [3:0]     be_l;
   logic [31:0]    wdata_l;
   logic [31:0]    lane;
   logic [31:0]    rdata_d;

   always_comb begin
      misaligned = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);
      timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
   end

   always_comb begin
      be_l    = 4'b1111;
      wdata_l = wdata_q;
      case (size_q)
         2'd0: begin
            be_l    = 4'b0001 << addr_q[1:0];
            wdata_l = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            be_l    = 4'b0011 << {addr_q[1], 1'b0};
            wdata_l = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   // Load data is extracted from the addressed lane using the latched request.
   always_comb begin
      lane    = mem_rdata >> {addr_q[1:0], 3'b000};
      rdata_d = mem_rdata;
      case (size_q)
         2'd0: rdata_d = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         2'd1: rdata_d = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= 2'd0;
         addr_q      <= 32'b0;
         wdata_q     <= 32'b0;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'b0;
         mem_req_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (misaligned) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 32'b0;
                  end else begin
                     we_q      <= req_we;
                     uns_q     <= req_unsigned;
                     size_q    <= req_size;
                     addr_q    <= req_addr;
                     wdata_q   <= req_wdata;
                     mem_req_q <= 1'b1;
                     state_q   <= REQ;
                  end
               end
            end
            REQ: begin
               cnt_q <= cnt_q + CW'(1);
               if (mem_gnt) begin
                  mem_req_q <= 1'b0;
                  if (we_q || mem_rvalid) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_rdata_q <= we_q ? 32'b0 : rdata_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end else if (timeout_hit) begin
                  mem_req_q   <= 1'b0;
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 32'b0;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q + CW'(1);
               if (mem_rvalid) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= rdata_d;
               end else if (timeout_hit) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 32'b0;
               end
            end
            RESP: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= 32'b0;
               busy_q      <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory-side fields are forced to zero whenever no request is outstanding.
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_req_q & we_q;
   assign mem_addr    = mem_req_q ? addr_q[MEM_AW+1:2] : '0;
   assign mem_be      = mem_req_q ? be_l : 4'b0000;
   assign mem_wdata   = mem_req_q ? wdata_l : 32'b0;
   assign req_ready   = req_ready_q;
   assign busy        = busy_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed plus randomized bench for cpu_lsu; a second instance with a short
// timeout covers the abort path.
module tb_cpu_lsu;

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // memory takes mem_req on an edge with mem_gnt; rsp_valid is a one-cycle pulse.

  logic        clk, rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        req_ready, rsp_valid, rsp_err, busy, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  logic        t_req_valid, t_mem_gnt, t_mem_rvalid;
  logic        t_req_ready, t_rsp_valid, t_rsp_err, t_busy, t_mem_req, t_mem_we;
  logic [31:0] t_rsp_rdata, t_mem_wdata;
  logic [11:0] t_mem_addr;
  logic [3:0]  t_mem_be;
  logic [1:0]  t_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  cpu_lsu #(.MEM_AW(12), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  cpu_lsu #(.MEM_AW(12), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(t_rsp_valid),
    .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err), .busy(t_busy), .mem_req(t_mem_req),
    .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be), .mem_wdata(t_mem_wdata),
    .mem_gnt(t_mem_gnt), .mem_rvalid(t_mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state_o(t_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic model_legal(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b0;
    if (size == 2'd1) return (addr % 2) == 0;
    if (size == 2'd2) return (addr % 4) == 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int off;
    off = addr % 4;
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << (off - off % 2));
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w % 256) * 32'h0101_0101;
    if (size == 2'd1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    v = rd / (32'd1 << (8 * (addr % 4)));
    if (size == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (size == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one full access on the main instance, starting and ending at a negedge
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gd, input int wt);
    logic legal;
    logic [32:0] got, exp;
    legal = model_legal(size, addr);
    if (!legal) exp_q.push_back({1'b1, 32'h0});
    else if (we) exp_q.push_back({1'b0, 32'h0});
    else exp_q.push_back({1'b0, model_load(size, uns, addr, rdata)});
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (legal) begin
      for (int i = 0; i <= gd; i++) begin
        chk("req_mem_req", mem_req, 1);
        chk("req_mem_we", mem_we, we);
        chk("req_mem_addr", mem_addr, (addr / 4) % 4096);
        chk("req_mem_be", mem_be, model_be(size, addr));
        if (we) chk("req_mem_wdata", mem_wdata, model_wdata(size, wdata));
        chk("req_busy", busy, 1);
        chk("req_ready_low", req_ready, 0);
        mem_rdata = $urandom;
        if (i == gd) begin
          mem_gnt = 1'b1;
          if (!we && wt == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
      if (!we && wt > 0) begin
        for (int i = 0; i < wt; i++) begin
          chk("wait_mem_req", mem_req, 0);
          chk("wait_no_rsp", rsp_valid, 0);
          mem_rdata = $urandom;
          @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end else begin
      chk("err_no_mem_req", mem_req, 0);
    end
    mem_rdata = $urandom;
    chk("rsp_valid", rsp_valid, 1);
    got = {rsp_err, rsp_rdata};
    chk("rsp_queue_nonempty", 33'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk("rsp_err_rdata", got, exp);
    end
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("rsp_idle_ready", req_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    t_req_valid = 1'b0; t_mem_gnt = 1'b0; t_mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed
    access(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0);
    access(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0, 0);
    access(1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0, 32'h12F4_3456, 0, 3);
    access(1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0, 32'h12F4_3456, 0, 3);
    access(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h12F4_3456, 1, 0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, 0);
    access(1'b0, 2'd3, 1'b0, 32'h0000_0004, 32'h0, 32'h0, 0, 0);
    access(1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0, 0);

    // randomized
    for (int n = 0; n < 60; n++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // timeout on the short-timeout instance
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
    t_req_valid = 1'b1;
    @(negedge clk);
    t_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_req_held", t_mem_req, 1);
      chk("to_no_rsp", t_rsp_valid, 0);
      @(negedge clk);
    end
    chk("to_mem_req_dropped", t_mem_req, 0);
    chk("to_rsp_valid", t_rsp_valid, 1);
    chk("to_rsp_err", t_rsp_err, 1);
    chk("to_rsp_rdata", t_rsp_rdata, 0);
    t_mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("to_late_ignored", t_rsp_valid, 0);
    @(negedge clk);
    t_mem_rvalid = 1'b0;
    chk("to_idle_ignored", t_rsp_valid, 0);
    chk("to_ready_again", t_req_ready, 1);
    req_we = 1'b1; req_size = 2'd1; req_addr = 32'h0000_0022; req_wdata = 32'h0000_BEEF;
    t_req_valid = 1'b1;
    @(negedge clk);
    t_req_valid = 1'b0;
    chk("to2_mem_be", t_mem_be, 4'b1100);
    chk("to2_mem_wdata", t_mem_wdata, 32'hBEEF_BEEF);
    t_mem_gnt = 1'b1;
    @(negedge clk);
    t_mem_gnt = 1'b0;
    chk("to2_rsp_valid", t_rsp_valid, 1);
    chk("to2_rsp_err", t_rsp_err, 0);
    @(negedge clk);

    // reset while in WAIT
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0100; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("pre_rst_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_idle", busy, 0);
    end
    mem_rvalid = 1'b0;
    access(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h8800_0000, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
